// File: rtl/ralu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ralu_sequencer
// Purpose  : Micro-sequencer on the issuing side of the RALU control
//            interface. One macro-instruction is accepted per start/ready
//            handshake and expanded into per-cycle control words
//            (adr, v, A, wr, ISL/ISR, S/M/Pin). The datapath result is
//            captured at writeback and reported with a one-cycle done pulse.
// Ports    : clock, reset (async, active-high)
//            start/ready          - instruction handshake
//            op, func, rd, rs1, rs2, count, fill - instruction fields
//            ralu_r/pout/osl/osr  - datapath result and shifted-out bits
//            S, M, Pin, A, wr, adr, v, ISL, ISR - RALU control word
//            done, result, carry, shout, zero   - completion and status
// Options  : RALU_SEQ_ZERO_FLAG_EN - when defined, zero captures
//            (ralu_r == 0) at writeback; otherwise zero is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module ralu_sequencer #(
    parameter int CNT_W = 2,
    parameter int ADR_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [5:0]       func,
    input  logic [ADR_W-1:0] rd,
    input  logic [ADR_W-1:0] rs1,
    input  logic [ADR_W-1:0] rs2,
    input  logic [CNT_W-1:0] count,
    input  logic             fill,
    input  logic [3:0]       ralu_r,
    input  logic             ralu_pout,
    input  logic             ralu_osl,
    input  logic             ralu_osr,
    output logic [3:0]       S,
    output logic             M,
    output logic             Pin,
    output logic             A,
    output logic             wr,
    output logic [ADR_W-1:0] adr,
    output logic [2:0]       v,
    output logic             ISL,
    output logic             ISR,
    output logic             ready,
    output logic             done,
    output logic [3:0]       result,
    output logic             carry,
    output logic             shout,
    output logic             zero
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LDA   = 3'd1,
        ST_LDB   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0]       OP_LOAD = 2'b01;
    localparam logic [1:0]       OP_SHR  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [5:0]       func_q, func_d;
    logic [ADR_W-1:0] rd_q, rd_d;
    logic [ADR_W-1:0] rs1_q, rs1_d;
    logic [ADR_W-1:0] rs2_q, rs2_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift_pend_q, shift_pend_d;
    logic [3:0]       result_q, result_d;
    logic             carry_q, carry_d;
    logic             shout_q, shout_d;
    logic             accept;

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept = start && ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            func_q       <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            count_q      <= '0;
            fill_q       <= 1'b0;
            cnt_q        <= '0;
            shift_pend_q <= 1'b0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            shout_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            func_q       <= func_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            count_q      <= count_d;
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            shift_pend_q <= shift_pend_d;
            result_q     <= result_d;
            carry_q      <= carry_d;
            shout_q      <= shout_d;
        end
    end

    // Next-state and datapath-capture logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        func_d   = func_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        count_d  = count_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;

        if (accept) begin
            op_d    = op;
            func_d  = func;
            rd_d    = rd;
            rs1_d   = rs1;
            rs2_d   = rs2;
            count_d = count;
            fill_d  = fill;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LDA;
            end
            ST_LDA: begin
                state_d = ST_LDB;
            end
            ST_LDB: begin
                cnt_d   = count_q;
                state_d = op_q[1] ? ST_SHIFT : ST_WB;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ZERO) state_d = ST_WB;
            end
            ST_WB: begin
                result_d = ralu_r;
                carry_d  = ralu_pout;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = accept ? ST_LDA : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The RALU registers its shifted-out bit on the shift edge, so the bit
    // becomes valid one edge later; a pending flag delays the capture.
    always_comb begin
        shift_pend_d = (state_q == ST_SHIFT);
        shout_d      = shout_q;
        if (shift_pend_q) begin
            shout_d = (op_q == OP_SHR) ? ralu_osr : ralu_osl;
        end
    end

    // Moore control-word decode: depends only on state and latched fields
    always_comb begin
        S    = 4'b0000;
        M    = 1'b0;
        Pin  = 1'b0;
        A    = 1'b0;
        wr   = 1'b0;
        adr  = '0;
        v    = 3'b000;
        ISL  = 1'b0;
        ISR  = 1'b0;
        done = 1'b0;

        if (state_q != ST_IDLE) begin
            {S, M, Pin} = func_q;
        end

        case (state_q)
            ST_LDA: begin
                adr = rs1_q;
                v   = 3'b001;
                A   = (op_q == OP_LOAD);
            end
            ST_LDB: begin
                adr = rs2_q;
                v   = 3'b110;
            end
            ST_SHIFT: begin
                adr = rs2_q;
                if (op_q == OP_SHR) begin
                    v   = 3'b100;
                    ISR = fill_q;
                end else begin
                    v   = 3'b010;
                    ISL = fill_q;
                end
            end
            ST_WB: begin
                adr = rd_q;
                wr  = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign shout  = shout_q;

`ifdef RALU_SEQ_ZERO_FLAG_EN
    logic zero_q, zero_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    always_comb begin
        zero_d = zero_q;
        if (state_q == ST_WB) begin
            zero_d = (ralu_r == 4'b0000);
        end
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ralu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ralu_sequencer
// Purpose  : Self-checking bench for ralu_sequencer with a small RALU model
//            (8 GPRs, regA, regB, ALU). Expected responses are queued at
//            issue time and compared by a monitor on each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ralu_sequencer;

`ifdef RALU_SEQ_ZERO_FLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op    = '0;
    logic [5:0] func  = '0;
    logic [2:0] rd    = '0;
    logic [2:0] rs1   = '0;
    logic [2:0] rs2   = '0;
    logic [1:0] count = '0;
    logic       fill  = 1'b0;
    logic [3:0] ralu_r;
    logic       ralu_pout;
    logic       ralu_osl, ralu_osr;
    logic [3:0] S;
    logic       M, Pin, A, wr, ISL, ISR, ready, done, carry, shout, zero;
    logic [2:0] adr, v;
    logic [3:0] result;

    always #5 clock = ~clock;

    ralu_sequencer #(.CNT_W(2), .ADR_W(3)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .func(func),
        .rd(rd), .rs1(rs1), .rs2(rs2), .count(count), .fill(fill),
        .ralu_r(ralu_r), .ralu_pout(ralu_pout),
        .ralu_osl(ralu_osl), .ralu_osr(ralu_osr),
        .S(S), .M(M), .Pin(Pin), .A(A), .wr(wr), .adr(adr), .v(v),
        .ISL(ISL), .ISR(ISR), .ready(ready), .done(done),
        .result(result), .carry(carry), .shout(shout), .zero(zero)
    );

    // ---------------- RALU model ----------------
    localparam logic [3:0] DATA_IN = 4'hA;
    logic [3:0] gpr [8];
    logic [3:0] rega, regb;
    logic       osl_r, osr_r;
    logic [4:0] alu;

    always_comb begin
        alu = 5'd0;
        if (!M) begin
            if (!S[0]) alu = {1'b0, rega} + {1'b0, regb} + {4'd0, Pin};
            else       alu = {1'b0, rega} + {1'b0, ~regb} + {4'd0, Pin};
        end else begin
            case (S[1:0])
                2'b00: alu = {1'b0, regb};
                2'b01: alu = {1'b0, rega & regb};
                2'b10: alu = {1'b0, rega ^ regb};
                default: alu = {1'b0, rega};
            endcase
        end
    end
    assign ralu_r    = alu[3:0];
    assign ralu_pout = alu[4];
    assign ralu_osl  = osl_r;
    assign ralu_osr  = osr_r;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            gpr[0] <= 4'h1; gpr[1] <= 4'h9; gpr[2] <= 4'h3; gpr[3] <= 4'h0;
            gpr[4] <= 4'h7; gpr[5] <= 4'h6; gpr[6] <= 4'hC; gpr[7] <= 4'h1;
            rega <= '0; regb <= '0; osl_r <= 1'b0; osr_r <= 1'b0;
        end else begin
            if (v[0]) rega <= A ? DATA_IN : gpr[adr];
            case (v[2:1])
                2'b11: regb <= gpr[adr];
                2'b01: begin regb <= {regb[2:0], ISL}; osl_r <= regb[3]; end
                2'b10: begin regb <= {ISR, regb[3:1]}; osr_r <= regb[0]; end
                default: ;
            endcase
            if (wr) gpr[adr] <= alu[3:0];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [3:0] r;
        logic       c, sh, z;
        int         lat, nsh, na;
        logic [2:0] shv;
        logic       isl, isr;
        logic [2:0] rd;
        logic [5:0] func;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0, n_bad = 0, n_stray = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] o, input logic [5:0] f, input logic [2:0] d,
                                input logic [1:0] c, input logic fl,
                                input logic [3:0] er, input logic ec, input logic es);
        exp_t e;
        e.r = er; e.c = ec; e.sh = es; e.z = ZF && (er == 4'h0);
        e.lat = o[1] ? 5 + int'(c) : 4;
        e.nsh = o[1] ? int'(c) + 1 : 0;
        e.na  = (o == 2'b01) ? 1 : 0;
        e.shv = (o == 2'b11) ? 3'b100 : 3'b010;
        e.isl = (o == 2'b10) ? fl : 1'b0;
        e.isr = (o == 2'b11) ? fl : 1'b0;
        e.rd = d; e.func = f;
        return e;
    endfunction

    // ---------------- monitor ----------------
    int         cyc = 0, acc_cyc = 0, nsh_any = 0, nsh_ok = 0, nwr = 0, na = 0, nbad_ser = 0;
    logic [2:0] wadr = '0;
    logic [5:0] wfunc = '0;
    bit         chk_lda = 1'b0;

    always @(negedge clock) begin
        bit shifting;
        exp_t e;
        cyc++;
        if (reset) begin
            nsh_any = 0; nsh_ok = 0; nwr = 0; na = 0; nbad_ser = 0; chk_lda = 1'b0;
        end else begin
            shifting = (v == 3'b010) || (v == 3'b100);
            if (chk_lda) begin
                chk("lda_after_accept", {29'd0, v}, 32'd1);
                chk_lda = 1'b0;
            end
            if (shifting) nsh_any++;
            if (shifting && sb.size() > 0 && v == sb[0].shv && ISL == sb[0].isl && ISR == sb[0].isr)
                nsh_ok++;
            if ((ISL || ISR) && !shifting) nbad_ser++;
            if (A) na++;
            if (wr) begin
                nwr++; wadr = adr; wfunc = {S, M, Pin};
                if (sb.size() == 0) n_stray++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_stray++;
                end else begin
                    e = sb.pop_front();
                    chk("result",   {28'd0, result}, {28'd0, e.r});
                    chk("carry",    {31'd0, carry},  {31'd0, e.c});
                    chk("shout",    {31'd0, shout},  {31'd0, e.sh});
                    chk("zero",     {31'd0, zero},   {31'd0, e.z});
                    chk("latency",  cyc - acc_cyc,   e.lat);
                    chk("shift_cycles", nsh_any,     e.nsh);
                    chk("shift_word",   nsh_ok,      e.nsh);
                    chk("serial_idle",  nbad_ser,    0);
                    chk("wr_pulses",    nwr,         1);
                    chk("wr_adr",   {29'd0, wadr},   {29'd0, e.rd});
                    chk("wb_func",  {26'd0, wfunc},  {26'd0, e.func});
                    chk("a_cycles", na,              e.na);
                end
                nsh_any = 0; nsh_ok = 0; nwr = 0; na = 0; nbad_ser = 0;
            end
            if (start && ready) begin
                acc_cyc = cyc;
                chk_lda = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_fields(input logic [1:0] o, input logic [5:0] f, input logic [2:0] d,
                              input logic [2:0] s1, input logic [2:0] s2,
                              input logic [1:0] c, input logic fl);
        op = o; func = f; rd = d; rs1 = s1; rs2 = s2; count = c; fill = fl;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ready) break;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [1:0] o, input logic [5:0] f, input logic [2:0] d,
                         input logic [2:0] s1, input logic [2:0] s2,
                         input logic [1:0] c, input logic fl,
                         input logic [3:0] er, input logic ec, input logic es, input bit push);
        if (push) sb.push_back(mk(o, f, d, c, fl, er, ec, es));
        @(posedge clock); #1;
        set_fields(o, f, d, s1, s2, c, fl);
        start = 1'b1;
        wait_ready();
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_outs"}, {7'd0, adr, v, A, wr, ISL, ISR, done, S, M, Pin, result, carry, shout, zero},
            32'd0);
        chk({nm, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        // reset state
        @(negedge clock);
        chk_quiet("reset");
        @(negedge clock);
        reset = 1'b0;

        // ALU add with Pin: 3 + 6 + 1 = A, with per-cycle control words
        issue(2'b00, 6'b000001, 3'd7, 3'd2, 3'd5, 2'd0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        chk("alu_c1", {26'd0, adr, v, A}, {26'd0, 3'd2, 3'b001, 1'b0});
        @(negedge clock);
        chk("alu_c2", {26'd0, adr, v, A}, {26'd0, 3'd5, 3'b110, 1'b0});
        @(negedge clock);
        chk("alu_c3", {20'd0, adr, v, wr, S, M, Pin}, {20'd0, 3'd7, 3'b000, 1'b1, 6'b000001});
        @(negedge clock);
        chk("alu_c4_done", {30'd0, done, ready}, 32'd3);
        wait_done();

        // LOAD DataIn into GPR3 via pass-A
        issue(2'b01, 6'b001110, 3'd3, 3'd0, 3'd1, 2'd0, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1);
        wait_done();
        chk("load_gpr3", {28'd0, gpr[3]}, 32'hA);

        // SHL x3 fill 1 on 1001 -> 1111, last out bit 0
        issue(2'b10, 6'b000010, 3'd4, 3'd0, 3'd1, 2'd2, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
        wait_done();
        chk("shl_regb", {28'd0, regb}, 32'hF);

        // SHR x1 fill 0 on 0001 -> 0000, out bit 1
        issue(2'b11, 6'b000010, 3'd5, 3'd0, 3'd0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        wait_done();

        // start held high: C + A = 16 (carry), then XOR same reg = 0
        sb.push_back(mk(2'b00, 6'b000000, 3'd1, 2'd0, 1'b0, 4'h6, 1'b1, 1'b1));
        sb.push_back(mk(2'b00, 6'b001010, 3'd0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1));
        @(posedge clock); #1;
        set_fields(2'b00, 6'b000000, 3'd1, 3'd6, 3'd3, 2'd0, 1'b0);
        start = 1'b1;
        wait_ready();
        @(posedge clock); #1;
        set_fields(2'b00, 6'b001010, 3'd0, 3'd2, 3'd2, 2'd0, 1'b0);
        wait_ready();
        chk("b2b_accept_in_done", {31'd0, done}, 32'd1);
        @(posedge clock); #1;
        start = 1'b0;
        wait_done();

        // reset in the middle of a shift aborts at once
        issue(2'b10, 6'b000010, 3'd6, 3'd0, 3'd1, 2'd3, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (v == 3'b010) break;
        end
        chk("abort_in_shift", {29'd0, v}, 32'd2);
        #3 reset = 1'b1;
        #1 chk_quiet("abort");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // fresh instruction after abort: C + 7 = 13 (carry)
        issue(2'b00, 6'b000000, 3'd2, 3'd6, 3'd4, 2'd0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1);
        wait_done();

        repeat (3) @(negedge clock);
        chk("stray_wr_done", n_stray, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ralu_sequencer.md
Name: ralu_sequencer

Overview:
- Micro-sequencer for the register ALU datapath: it is the issuing end of the RALU control interface.
- Accepts one macro-instruction per start handshake and expands it into per-cycle control words: adr, v, A, wr, ISL/ISR, S/M/Pin.
- Samples the datapath result (R, Pout, OSL/OSR) at writeback and reports done plus captured result and flags to the instruction source.
- Sits between the instruction fetch/decode stage and the RALU, in the same clock/reset domain.

Parameters:
- CNT_W, 2, width of the shift-count field; shift runs count+1 times (1..2^CNT_W).
- ADR_W, 3, GPR address width (8 registers).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clock is clock
- start  in  1  instruction valid; accepted only when ready=1
- op  in  2  00 ALU, 01 LOAD, 10 SHL, 11 SHR
- func  in  6  {S[3:0],M,Pin}, the ALU function, applied unchanged at writeback
- rd, rs1, rs2  in  ADR_W each  destination and sources
- count  in  CNT_W  shift count minus one
- fill  in  1  serial fill bit for shifts
- ralu_r  in  4  RALU R
- ralu_pout  in  1  RALU Pout
- ralu_osl, ralu_osr  in  1 each  RALU shifted-out bits
- S  out  4;  M  out  1;  Pin  out  1  ALU function
- A  out  1  regA source select (1 = DataIn)
- wr  out  1  GPR write strobe
- adr  out  ADR_W  GPR address
- v  out  3  register load/shift enables
- ISL, ISR  out  1 each  serial inputs
- ready  out  1  can accept start
- done  out  1  one-cycle completion pulse
- result  out  4  captured R
- carry  out  1  captured Pout
- shout  out  1  last shifted-out bit
- zero  out  1  see Optional Feature

Behaviour:
- Reset (async): state IDLE. Latched fields are 0. All outputs are 0 except ready=1.
- States: IDLE, LDA, LDB, SHIFT, WB, DONE. ready=1 in IDLE and DONE only.
- Accept: start&ready at a clock edge latches op, func, rd, rs1, rs2, count, fill, and moves to LDA. start with ready=0 is ignored; no queueing. Back-to-back accept from DONE is allowed.
- LDA: adr=rs1, v=001, A=(op==LOAD). Next state LDB.
- LDB: adr=rs2, v=110. Next state is SHIFT if op is SHL or SHR, else WB. Shift counter loads count.
- SHIFT: adr=rs2 (don't-care), v=010 for SHL with ISL=fill, or v=100 for SHR with ISR=fill.
  - Every SHIFT cycle the sequencer registers shout from ralu_osl (SHL) or ralu_osr (SHR) at the clock edge following the shift edge.
  - The counter decrements each cycle; the state leaves to WB after the cycle in which the counter is 0. That gives count+1 shift cycles.
- WB: adr=rd, wr=1, v=000. result<=ralu_r and carry<=ralu_pout at the WB edge. Next state DONE.
- DONE: done=1 for exactly one cycle. Next state is LDA if a start is accepted, else IDLE.
- {S,M,Pin} come from latched func in every non-IDLE state; they are 0 in IDLE.
- Outputs are Moore, decoded from state plus latched fields, with no combinational path from start.
- adr/v/A/wr/ISL/ISR are 0 in IDLE and DONE. ISL/ISR are 0 outside SHIFT.
- Latency start→done: 4 cycles for ALU/LOAD; 5+count for shifts.
- result, carry, shout and zero hold until the next WB (or shift, for shout).
- Reset mid-operation aborts immediately: no wr pulse and no done pulse. The partially loaded RALU registers are don't-care.
- rd may equal rs1 or rs2: the write happens only in WB, after both reads, so there is no hazard.

Optional Feature:
- Macro RALU_SEQ_ZERO_FLAG_EN.
- Defined: zero<=(ralu_r==4'b0000) is captured at the WB edge alongside result.
- Undefined: zero is tied to 0; no flag register is synthesized.

Test Plan:
- Reset, then ALU op with rs1=2, rs2=5, rd=7, func=F0 → cycles after accept: adr=2/v=001; adr=5/v=110; adr=7/wr=1 with S/M/Pin=F0; then done=1. result equals the RALU model R for GPR2,GPR5.
- LOAD with DataIn=4'hA, rd=3, func set to pass-A → A=1 only in LDA. After done, GPR3=4'hA, result=4'hA, zero=0 (flag build).
- SHL with count=2, fill=1, rs2 holding 4'b1001 → exactly 3 SHIFT cycles with v=010, ISL=1. regB ends 4'b1111, shout=0, done at cycle 7.
- SHR with count=0, fill=0, rs2 holding 4'b0001 → 1 SHIFT cycle with v=100, shout=1, done at cycle 5.
- start held high continuously → second instruction accepted in the DONE cycle, next LDA immediately follows, no idle cycle. start pulses while busy are ignored.
- Assert reset during SHIFT → all outputs 0 and ready=1 at once, wr never pulses, no done. A fresh instruction afterwards completes normally.
